// File: rtl/uart_cfg_pkg.sv
// Shared constants, FSM encodings and the parity helper for the configurable UART.
package uart_cfg_pkg;

   localparam int unsigned PARITY_NONE   = 0;
   localparam int unsigned PARITY_ODD    = 1;
   localparam int unsigned PARITY_EVEN   = 2;
   localparam int unsigned MAX_DATA_BITS = 9;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_WAIT_IDLE
   } rx_state_e;

   // Zero-extended data does not change the XOR, so one width serves every DATA_BITS.
   function automatic logic parity_bit(input int unsigned mode,
                                       input logic [MAX_DATA_BITS-1:0] data);
      logic p;
      p = ^data;
      if (mode == PARITY_ODD)  return ~p;
      if (mode == PARITY_EVEN) return p;
      return 1'b0;
   endfunction

endpackage

// File: rtl/uart_rx_engine.sv
// RX line synchroniser, mid-bit sampling FSM and shifter; emits a one-cycle frame-done strobe.
module uart_rx_engine
   import uart_cfg_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 1085,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY       = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx_phy_i,
   output logic                 frame_done_c_o,
   output logic                 frame_err_c_o,
   output logic [DATA_BITS-1:0] data_o,
   output logic                 par_err_o,
   output logic                 busy_o
);

   localparam int unsigned   CW       = $clog2(CLKS_PER_BIT);
   localparam int unsigned   IW       = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

   logic [1:0]           sync_q;
   logic                 rx_s;
   rx_state_e            state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_err_q, par_err_d;
   logic                 busy_q;

   assign rx_s      = sync_q[1];
   assign data_o    = shift_q;
   assign par_err_o = par_err_q;
   assign busy_o    = busy_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q    <= 2'b11;
         state_q   <= RX_IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         par_err_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         sync_q    <= {sync_q[0], rx_phy_i};
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         par_err_q <= par_err_d;
         busy_q    <= (state_d != RX_IDLE);
      end
   end

   // Start bit is re-checked at its middle; later samples land one bit period apart.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      idx_d          = idx_q;
      shift_d        = shift_q;
      par_err_d      = par_err_q;
      frame_done_c_o = 1'b0;
      frame_err_c_o  = 1'b0;
      case (state_q)
         RX_IDLE: begin
            if (!rx_s) begin
               state_d = RX_START;
               cnt_d   = '0;
            end
         end
         RX_START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d     = '0;
               idx_d     = '0;
               par_err_d = 1'b0;
               state_d   = rx_s ? RX_IDLE : RX_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
               if (idx_q == IDX_LAST) begin
                  state_d = (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_PARITY: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d     = '0;
               par_err_d = (rx_s != parity_bit(PARITY, MAX_DATA_BITS'(shift_q)));
               state_d   = RX_STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d          = '0;
               frame_done_c_o = 1'b1;
               frame_err_c_o  = !rx_s;
               state_d        = rx_s ? RX_IDLE : RX_WAIT_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_WAIT_IDLE: begin
            if (rx_s) state_d = RX_IDLE;
         end
         default: state_d = RX_IDLE;
      endcase
   end

endmodule

// File: rtl/uart_core_cfg.sv
// Configurable full-duplex UART: TX FSM, RX engine instance and the RX valid/ready output register.
module uart_core_cfg
   import uart_cfg_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 1085,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY       = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx_phy,
   output logic                 tx_busy,
   input  logic                 rx_phy,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 rx_parity_err,
   output logic                 rx_frame_err,
   output logic                 rx_overrun,
   output logic                 rx_busy
);

   localparam int unsigned   CW        = $clog2(CLKS_PER_BIT);
   localparam int unsigned   IW        = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_PRE   = CW'(CLKS_PER_BIT - 2);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
   localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

   tx_state_e            tx_state_q, tx_state_d;
   logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
   logic [IW-1:0]        tx_idx_q, tx_idx_d;
   logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
   logic                 tx_par_q, tx_par_d;
   logic                 tx_phy_q, tx_phy_d;
   logic                 tx_ready_q, tx_busy_q;

   logic                 frame_done_c, frame_err_c;
   logic [DATA_BITS-1:0] eng_data;
   logic                 eng_par_err;

   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 rx_perr_q, rx_perr_d;
   logic                 rx_ferr_q, rx_ferr_d;
   logic                 rx_ovr_q, rx_ovr_d;

   assign tx_ready      = tx_ready_q;
   assign tx_busy       = tx_busy_q;
   assign tx_phy        = tx_phy_q;
   assign rx_data       = rx_data_q;
   assign rx_valid      = rx_valid_q;
   assign rx_parity_err = rx_perr_q;
   assign rx_frame_err  = rx_ferr_q;
   assign rx_overrun    = rx_ovr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_idx_q   <= '0;
         tx_shift_q <= '0;
         tx_par_q   <= 1'b0;
         tx_phy_q   <= 1'b1;
         tx_ready_q <= 1'b1;
         tx_busy_q  <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_idx_q   <= tx_idx_d;
         tx_shift_q <= tx_shift_d;
         tx_par_q   <= tx_par_d;
         tx_phy_q   <= tx_phy_d;
         tx_ready_q <= (tx_state_d == TX_IDLE);
         tx_busy_q  <= (tx_state_d != TX_IDLE);
      end
   end

   // STOP leaves one cycle early so IDLE covers the final stop cycle and frames can abut.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_idx_d   = tx_idx_q;
      tx_shift_d = tx_shift_q;
      tx_par_d   = tx_par_q;
      tx_phy_d   = 1'b1;
      case (tx_state_q)
         TX_IDLE: begin
            if (tx_valid) begin
               tx_state_d = TX_START;
               tx_cnt_d   = '0;
               tx_shift_d = tx_data;
               tx_par_d   = parity_bit(PARITY, MAX_DATA_BITS'(tx_data));
            end
         end
         TX_START: begin
            if (tx_cnt_q == CNT_LAST) begin
               tx_cnt_d   = '0;
               tx_idx_d   = '0;
               tx_state_d = TX_DATA;
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         TX_DATA: begin
            if (tx_cnt_q == CNT_LAST) begin
               tx_cnt_d = '0;
               if (tx_idx_q == IDX_LAST) begin
                  tx_idx_d   = '0;
                  tx_state_d = (PARITY != PARITY_NONE) ? TX_PARITY : TX_STOP;
               end else begin
                  tx_idx_d   = tx_idx_q + 1'b1;
                  tx_shift_d = tx_shift_q >> 1;
               end
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         TX_PARITY: begin
            if (tx_cnt_q == CNT_LAST) begin
               tx_cnt_d   = '0;
               tx_idx_d   = '0;
               tx_state_d = TX_STOP;
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         TX_STOP: begin
            if ((tx_idx_q == STOP_LAST) && (tx_cnt_q == CNT_PRE)) begin
               tx_state_d = TX_IDLE;
            end else if (tx_cnt_q == CNT_LAST) begin
               tx_cnt_d = '0;
               tx_idx_d = tx_idx_q + 1'b1;
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase

      case (tx_state_d)
         TX_START:  tx_phy_d = 1'b0;
         TX_DATA:   tx_phy_d = tx_shift_d[0];
         TX_PARITY: tx_phy_d = tx_par_d;
         default:   tx_phy_d = 1'b1;
      endcase
   end

   uart_rx_engine #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .DATA_BITS    (DATA_BITS),
      .PARITY       (PARITY)
   ) u_rx_engine (
      .clk            (clk),
      .rst_n          (rst_n),
      .rx_phy_i       (rx_phy),
      .frame_done_c_o (frame_done_c),
      .frame_err_c_o  (frame_err_c),
      .data_o         (eng_data),
      .par_err_o      (eng_par_err),
      .busy_o         (rx_busy)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_perr_q  <= 1'b0;
         rx_ferr_q  <= 1'b0;
         rx_ovr_q   <= 1'b0;
      end else begin
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         rx_perr_q  <= rx_perr_d;
         rx_ferr_q  <= rx_ferr_d;
         rx_ovr_q   <= rx_ovr_d;
      end
   end

   // A completed frame only lands if the slot is empty or being drained this cycle.
   always_comb begin
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      rx_perr_d  = rx_perr_q;
      rx_ferr_d  = rx_ferr_q;
      rx_ovr_d   = 1'b0;
      if (frame_done_c) begin
         if (!rx_valid_q || rx_ready) begin
            rx_data_d  = eng_data;
            rx_perr_d  = eng_par_err;
            rx_ferr_d  = frame_err_c;
            rx_valid_d = 1'b1;
         end else begin
            rx_ovr_d = 1'b1;
         end
      end else if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_core_cfg.sv
// Scoreboard bench for uart_core_cfg: an 8N1 and an 8E1 instance, loopback and bench-driven RX frames.
module tb_uart_core_cfg;

   localparam int CPB = 16;

   typedef struct packed {
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } exp_t;

   logic clk, rst_n;
   logic [7:0] tx_data_a, tx_data_b, rx_data_a, rx_data_b;
   logic tx_valid_a, tx_valid_b, tx_ready_a, tx_ready_b;
   logic tx_phy_a, tx_phy_b, tx_busy_a, tx_busy_b;
   logic rx_phy_a, rx_phy_b, rx_valid_a, rx_valid_b, rx_ready_a, rx_ready_b;
   logic rx_perr_a, rx_perr_b, rx_ferr_a, rx_ferr_b;
   logic rx_ovr_a, rx_ovr_b, rx_busy_a, rx_busy_b;
   logic loop_a, loop_b, drv_a, drv_b;

   exp_t qa[$];
   exp_t qb[$];
   int n_checks = 0;
   int n_errors = 0;
   int rx_cnt_a = 0;
   int rx_cnt_b = 0;
   int ovr_a    = 0;

   assign rx_phy_a = loop_a ? tx_phy_a : drv_a;
   assign rx_phy_b = loop_b ? tx_phy_b : drv_b;

   uart_core_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
      .tx_phy(tx_phy_a), .tx_busy(tx_busy_a),
      .rx_phy(rx_phy_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
      .rx_parity_err(rx_perr_a), .rx_frame_err(rx_ferr_a), .rx_overrun(rx_ovr_a),
      .rx_busy(rx_busy_a)
   );

   uart_core_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
      .tx_phy(tx_phy_b), .tx_busy(tx_busy_b),
      .rx_phy(rx_phy_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
      .rx_parity_err(rx_perr_b), .rx_frame_err(rx_ferr_b), .rx_overrun(rx_ovr_b),
      .rx_busy(rx_busy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_line(input bit sel, input logic v);
      if (sel) drv_b = v;
      else     drv_a = v;
   endtask

   // Scoreboard pop: every rx transfer must match the oldest expected frame.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && rx_valid_a && rx_ready_a) begin
         check_eq("a_sb_avail", 32'(qa.size() > 0), 32'd1);
         if (qa.size() > 0) begin
            e = qa.pop_front();
            check_eq("a_rx_data", 32'(rx_data_a), 32'(e.d));
            check_eq("a_rx_perr", 32'(rx_perr_a), 32'(e.pe));
            check_eq("a_rx_ferr", 32'(rx_ferr_a), 32'(e.fe));
         end
         rx_cnt_a++;
      end
      if (rst_n && rx_valid_b && rx_ready_b) begin
         check_eq("b_sb_avail", 32'(qb.size() > 0), 32'd1);
         if (qb.size() > 0) begin
            e = qb.pop_front();
            check_eq("b_rx_data", 32'(rx_data_b), 32'(e.d));
            check_eq("b_rx_perr", 32'(rx_perr_b), 32'(e.pe));
            check_eq("b_rx_ferr", 32'(rx_ferr_b), 32'(e.fe));
         end
         rx_cnt_b++;
      end
      if (rst_n && rx_ovr_a) ovr_a++;
   end

   // Send one byte and check the serial waveform at each mid-bit plus the frame length.
   task automatic tx_frame_check(input bit sel, input logic [7:0] d, input int pmode, input string tag);
      logic [11:0] eb;
      int nb, f, first_rdy, t, b;
      logic cur;
      eb = '1;
      eb[0] = 1'b0;
      eb[8:1] = d;
      if (pmode == 1) eb[9] = ~^d;
      if (pmode == 2) eb[9] = ^d;
      nb = (pmode != 0) ? 11 : 10;
      f = nb * CPB;
      t = 0;
      while (!(sel ? tx_ready_b : tx_ready_a) && t < 400) begin
         cyc(1);
         t++;
      end
      check_eq({tag, "_ready"}, 32'(sel ? tx_ready_b : tx_ready_a), 32'd1);
      if (sel ? loop_b : loop_a) begin
         if (sel) qb.push_back('{d: d, pe: 1'b0, fe: 1'b0});
         else     qa.push_back('{d: d, pe: 1'b0, fe: 1'b0});
      end
      if (sel) begin tx_data_b = d; tx_valid_b = 1'b1; end
      else     begin tx_data_a = d; tx_valid_a = 1'b1; end
      cyc(1);
      tx_valid_a = 1'b0;
      tx_valid_b = 1'b0;
      check_eq({tag, "_start_edge"}, 32'(sel ? tx_phy_b : tx_phy_a), 32'd0);
      check_eq({tag, "_busy"}, 32'(sel ? tx_busy_b : tx_busy_a), 32'd1);
      first_rdy = 0;
      for (int k = 1; k <= f; k++) begin
         cur = sel ? tx_phy_b : tx_phy_a;
         if ((k % CPB) == CPB / 2) begin
            b = k / CPB;
            check_eq($sformatf("%s_bit%0d", tag, b), 32'(cur), 32'(eb[b]));
         end
         if ((sel ? tx_ready_b : tx_ready_a) && first_rdy == 0) first_rdy = k;
         cyc(1);
      end
      check_eq({tag, "_frame_len"}, 32'(first_rdy), 32'(f));
   endtask

   // Drive one 8-bit frame on a bench-controlled RX line.
   task automatic rx_drive(input bit sel, input logic [7:0] d, input bit has_par,
                           input bit par, input bit stop);
      set_line(sel, 1'b0);
      cyc(CPB);
      for (int i = 0; i < 8; i++) begin
         set_line(sel, d[i]);
         cyc(CPB);
      end
      if (has_par) begin
         set_line(sel, par);
         cyc(CPB);
      end
      set_line(sel, stop);
      cyc(CPB);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, t;
      bit seen;
      rst_n = 1'b0;
      tx_data_a = '0; tx_data_b = '0;
      tx_valid_a = 1'b0; tx_valid_b = 1'b0;
      rx_ready_a = 1'b1; rx_ready_b = 1'b1;
      loop_a = 1'b1; loop_b = 1'b1;
      drv_a = 1'b1; drv_b = 1'b1;
      #23;
      check_eq("rst_tx_phy",   32'(tx_phy_a),   32'd1);
      check_eq("rst_tx_ready", 32'(tx_ready_a), 32'd1);
      check_eq("rst_tx_busy",  32'(tx_busy_a),  32'd0);
      check_eq("rst_rx_valid", 32'(rx_valid_a), 32'd0);
      check_eq("rst_rx_data",  32'(rx_data_a),  32'd0);
      check_eq("rst_rx_errs",  32'({rx_perr_a, rx_ferr_a, rx_ovr_a}), 32'd0);
      check_eq("rst_rx_busy",  32'(rx_busy_a),  32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      cyc(5);

      // 1: 8N1 loopback of 0xA5
      tx_frame_check(1'b0, 8'hA5, 0, "t1");
      cyc(20);

      // 2: 8E1 loopback of 0x07, then a driven frame with the wrong parity bit
      tx_frame_check(1'b1, 8'h07, 2, "t2");
      cyc(20);
      loop_b = 1'b0;
      cyc(CPB);
      qb.push_back('{d: 8'h07, pe: 1'b1, fe: 1'b0});
      rx_drive(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
      cyc(20);

      // 3: false start
      loop_a = 1'b0;
      cyc(20);
      base = rx_cnt_a;
      seen = 1'b0;
      drv_a = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         if (rx_busy_a) seen = 1'b1;
      end
      drv_a = 1'b1;
      t = 0;
      while (rx_busy_a && t < 10) begin
         cyc(1);
         t++;
      end
      check_eq("t3_busy_seen", 32'(seen), 32'd1);
      check_eq("t3_busy_clear", 32'(rx_busy_a), 32'd0);
      cyc(200);
      check_eq("t3_no_frame", 32'(rx_cnt_a), 32'(base));

      // 4: framing error followed by a break
      base = rx_cnt_a;
      qa.push_back('{d: 8'h3C, pe: 1'b0, fe: 1'b1});
      rx_drive(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
      cyc(100);
      check_eq("t4_one_frame", 32'(rx_cnt_a), 32'(base + 1));
      check_eq("t4_busy_break", 32'(rx_busy_a), 32'd1);
      drv_a = 1'b1;
      cyc(40);
      check_eq("t4_busy_after", 32'(rx_busy_a), 32'd0);
      check_eq("t4_still_one", 32'(rx_cnt_a), 32'(base + 1));

      // 5: overrun while the consumer stalls
      rx_ready_a = 1'b0;
      qa.push_back('{d: 8'h11, pe: 1'b0, fe: 1'b0});
      rx_drive(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
      cyc(CPB);
      rx_drive(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
      cyc(CPB);
      check_eq("t5_valid_held", 32'(rx_valid_a), 32'd1);
      check_eq("t5_data_held", 32'(rx_data_a), 32'h11);
      check_eq("t5_overrun_pulses", 32'(ovr_a), 32'd1);
      rx_ready_a = 1'b1;
      cyc(1);
      check_eq("t5_valid_clear", 32'(rx_valid_a), 32'd0);

      // 6: reset in the middle of data bit 3, then a clean frame
      loop_a = 1'b1;
      cyc(10);
      t = 0;
      while (!tx_ready_a && t < 400) begin
         cyc(1);
         t++;
      end
      tx_data_a = 8'h00;
      tx_valid_a = 1'b1;
      cyc(1);
      tx_valid_a = 1'b0;
      cyc(4 * CPB + CPB / 2);
      check_eq("t6_pre_rst_phy", 32'(tx_phy_a), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check_eq("t6_async_phy", 32'(tx_phy_a), 32'd1);
      check_eq("t6_async_busy", 32'(tx_busy_a), 32'd0);
      cyc(2);
      rst_n = 1'b1;
      cyc(1);
      check_eq("t6_ready_after", 32'(tx_ready_a), 32'd1);
      tx_frame_check(1'b0, 8'h5A, 0, "t6");
      cyc(30);

      check_eq("end_qa_empty", 32'(qa.size()), 32'd0);
      check_eq("end_qb_empty", 32'(qb.size()), 32'd0);
      check_eq("end_rx_cnt_a", 32'(rx_cnt_a), 32'd4);
      check_eq("end_rx_cnt_b", 32'(rx_cnt_b), 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
